chip8_rom_loader: RTL

//  Bus initiator that drives the Chip8 top-level register/memory slave port (chipselect/write/address/writedata/data_out).

---
 rtl/chip8_rom_loader.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/chip8_rom_loader.sv
// Streams a ROM image into Chip8 memory over its register/memory slave port, then sets pc and run.
// Optional read-back verification of every byte: define CHIP8_LOADER_VERIFY_EN.
module chip8_rom_loader #(
  parameter logic [11:0] BASE_ADDR = 12'h200,
  parameter logic [17:0] MEM_WIN   = 18'h10000,
  parameter logic [17:0] REG_PC    = 18'h14,
  parameter logic [17:0] REG_STATE = 18'h16,
  parameter logic [1:0]  ST_RUN    = 2'h0,
  parameter logic [1:0]  ST_LOAD   = 2'h2,
  parameter int unsigned RD_LAT    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [12:0] len,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        chipselect,
  output logic        write,
  output logic [17:0] address,
  output logic [31:0] writedata,
  input  logic [31:0] data_out
);

  // Largest image that fits between BASE_ADDR and the top of the 4 KiB space.
  localparam logic [12:0] LenLimit = 13'h1000 - {1'b0, BASE_ADDR};

  typedef enum logic [2:0] {
    StIdle,
    StSetLoad,
    StStream,
    StVerRd,
    StVerWait,
    StSetPc,
    StSetRun,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [12:0] len_q, len_d;
  logic [12:0] cnt_q, cnt_d;
  logic [7:0]  byte_q, byte_d;
  logic        pend_q, pend_d;
  logic        error_q, error_d;
  logic        bad_done_q, bad_done_d;
  logic [11:0] mem_addr;
  logic        last;

`ifdef CHIP8_LOADER_VERIFY_EN
  logic [7:0]  wcnt_q, wcnt_d;
`else
  logic        unused_data;
  assign unused_data = ^data_out;
`endif

  assign mem_addr = BASE_ADDR + cnt_q[11:0];
  assign last     = ((cnt_q + 13'd1) == len_q);
  assign error    = error_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      len_q      <= '0;
      cnt_q      <= '0;
      byte_q     <= '0;
      pend_q     <= 1'b0;
      error_q    <= 1'b0;
      bad_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      byte_q     <= byte_d;
      pend_q     <= pend_d;
      error_q    <= error_d;
      bad_done_q <= bad_done_d;
    end
  end

`ifdef CHIP8_LOADER_VERIFY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wcnt_q <= '0;
    end else begin
      wcnt_q <= wcnt_d;
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    byte_d     = byte_q;
    pend_d     = pend_q;
    error_d    = error_q;
    bad_done_d = 1'b0;
`ifdef CHIP8_LOADER_VERIFY_EN
    wcnt_d     = wcnt_q;
`endif
    in_ready   = 1'b0;
    busy       = 1'b0;
    done       = bad_done_q;
    chipselect = 1'b0;
    write      = 1'b0;
    address    = '0;
    writedata  = '0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (len <= LenLimit) begin
            len_d   = len;
            cnt_d   = '0;
            pend_d  = 1'b0;
            error_d = 1'b0;
            state_d = StSetLoad;
          end else begin
            // Rejected length: flag it and pulse done, but touch nothing on the bus.
            error_d    = 1'b1;
            bad_done_d = 1'b1;
          end
        end
      end

      StSetLoad: begin
        busy       = 1'b1;
        chipselect = 1'b1;
        write      = 1'b1;
        address    = REG_STATE;
        writedata  = {30'b0, ST_LOAD};
        state_d    = (len_q == 13'd0) ? StSetPc : StStream;
      end

      StStream: begin
        busy     = 1'b1;
        in_ready = !pend_q;
        if (pend_q) begin
          chipselect = 1'b1;
          write      = 1'b1;
          address    = MEM_WIN | {6'b0, mem_addr};
          writedata  = {24'b0, byte_q};
          pend_d     = 1'b0;
`ifdef CHIP8_LOADER_VERIFY_EN
          // cnt advances only once the read-back matches, so the read reuses mem_addr.
          state_d    = StVerRd;
`else
          cnt_d      = cnt_q + 13'd1;
          if (last) begin
            state_d = StSetPc;
          end
`endif
        end else if (in_valid) begin
          byte_d = in_data;
          pend_d = 1'b1;
        end
      end

`ifdef CHIP8_LOADER_VERIFY_EN
      StVerRd: begin
        busy       = 1'b1;
        chipselect = 1'b1;
        address    = MEM_WIN | {6'b0, mem_addr};
        wcnt_d     = '0;
        state_d    = StVerWait;
      end

      StVerWait: begin
        busy = 1'b1;
        if (wcnt_q == 8'(RD_LAT - 1)) begin
          if (data_out[7:0] != byte_q) begin
            // Leave the CPU halted in the loading state.
            error_d = 1'b1;
            state_d = StDone;
          end else begin
            cnt_d   = cnt_q + 13'd1;
            state_d = last ? StSetPc : StStream;
          end
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end
`endif

      StSetPc: begin
        busy       = 1'b1;
        chipselect = 1'b1;
        write      = 1'b1;
        address    = REG_PC;
        writedata  = {20'b0, BASE_ADDR};
        state_d    = StSetRun;
      end

      StSetRun: begin
        busy       = 1'b1;
        chipselect = 1'b1;
        write      = 1'b1;
        address    = REG_STATE;
        writedata  = {30'b0, ST_RUN};
        state_d    = StDone;
      end

      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

endmodule
